// File: rtl/scr1_dmem_router_mp.sv
// Data-memory router: fans one LSU request stream out to PORT_NUM targets and returns in-order responses.
// Optional error capture of the failing port/address is enabled with SCR1_DMEM_ROUTER_ERR_CAPTURE_EN.
module scr1_dmem_router_mp #(
  parameter int unsigned                   PORT_NUM     = 3,
  parameter int unsigned                   OUTST_DEPTH  = 2,
  parameter int unsigned                   AWIDTH       = 32,
  parameter int unsigned                   DWIDTH       = 32,
  parameter int unsigned                   LANES        = 4,
  parameter logic [PORT_NUM*AWIDTH-1:0]    ADDR_MASK    = {PORT_NUM{32'hFFFF0000}},
  parameter logic [PORT_NUM*AWIDTH-1:0]    ADDR_PATTERN = {32'h00020000, 32'h00010000, 32'h0},
  parameter logic [PORT_NUM-1:0]           PORT_WIDE    = 3'b010
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                dmem_req,
  output logic                                dmem_req_ack,
  input  logic                                dmem_cmd,
  input  logic [1:0]                          dmem_width,
  input  logic [AWIDTH-1:0]                   dmem_addr,
  input  logic [LANES*DWIDTH-1:0]             dmem_wdata,
  output logic [LANES*DWIDTH-1:0]             dmem_rdata,
  output logic [1:0]                          dmem_resp,
  output logic [PORT_NUM-1:0]                 port_req,
  input  logic [PORT_NUM-1:0]                 port_req_ack,
  output logic [PORT_NUM-1:0]                 port_cmd,
  output logic [2*PORT_NUM-1:0]               port_width,
  output logic [PORT_NUM*AWIDTH-1:0]          port_addr,
  output logic [PORT_NUM*LANES*DWIDTH-1:0]    port_wdata,
  input  logic [PORT_NUM*LANES*DWIDTH-1:0]    port_rdata,
  input  logic [2*PORT_NUM-1:0]               port_resp
`ifdef SCR1_DMEM_ROUTER_ERR_CAPTURE_EN
  ,
  input  logic                                err_clr,
  output logic                                err_valid,
  output logic [$clog2(PORT_NUM)-1:0]         err_port,
  output logic [AWIDTH-1:0]                   err_addr
`endif
);

  localparam int unsigned VW = LANES*DWIDTH;
  localparam int unsigned SW = $clog2(PORT_NUM);
  localparam int unsigned CW = $clog2(OUTST_DEPTH+1);

  localparam logic [1:0] RESP_IDLE   = 2'b00;
  localparam logic [1:0] RESP_RDY_OK = 2'b01;
  localparam logic [1:0] RESP_RDY_ER = 2'b10;
  localparam logic       CMD_ERROR   = 1'bx;
  localparam logic [1:0] WIDTH_ERROR = 2'bxx;

  logic [SW-1:0] sel;
  logic [SW-1:0] cur_port;
  logic [CW-1:0] cnt;
  logic [1:0]    cur_resp;
  logic [VW-1:0] cur_rdata;
  logic          sel_ack;
  logic          retire;
  logic          can_issue;
  logic          req_go;
  logic          accept;

  // Lowest matching port wins; port 0 is the fall-through target.
  always_comb begin
    logic found;
    sel   = '0;
    found = 1'b0;
    for (int unsigned i = 1; i < PORT_NUM; i++) begin
      if (!found && ((dmem_addr & ADDR_MASK[i*AWIDTH +: AWIDTH]) == ADDR_PATTERN[i*AWIDTH +: AWIDTH])) begin
        sel   = SW'(i);
        found = 1'b1;
      end
    end
  end

  always_comb begin
    cur_resp  = RESP_IDLE;
    cur_rdata = '0;
    sel_ack   = 1'b0;
    for (int unsigned p = 0; p < PORT_NUM; p++) begin
      if (SW'(p) == cur_port) begin
        cur_resp  = port_resp[2*p +: 2];
        cur_rdata = PORT_WIDE[p] ? port_rdata[p*VW +: VW] : VW'(port_rdata[p*VW +: DWIDTH]);
      end
      if (SW'(p) == sel) sel_ack = port_req_ack[p];
    end
  end

  assign retire    = (cnt != '0) && ((cur_resp == RESP_RDY_OK) || (cur_resp == RESP_RDY_ER));
  // A port switch waits until the last outstanding entry is retiring, keeping responses in order.
  assign can_issue = (cnt == '0)
                   || ((sel == cur_port) && ((cnt < CW'(OUTST_DEPTH)) || retire))
                   || ((cnt == CW'(1)) && retire);
  assign req_go       = ~rst & dmem_req & can_issue;
  assign dmem_req_ack = req_go & sel_ack;
  assign accept       = dmem_req_ack;

  always_comb begin
    port_req   = '0;
    port_cmd   = '0;
    port_width = '0;
    port_addr  = '0;
    port_wdata = '0;
    for (int unsigned p = 0; p < PORT_NUM; p++) begin
      port_cmd[p]                = CMD_ERROR;
      port_width[2*p +: 2]       = WIDTH_ERROR;
      port_addr[p*AWIDTH +: AWIDTH] = 'x;
      if (sel == SW'(p)) begin
        port_req[p]                   = req_go;
        port_cmd[p]                   = dmem_cmd;
        port_width[2*p +: 2]          = dmem_width;
        port_addr[p*AWIDTH +: AWIDTH] = dmem_addr;
      end
      port_wdata[p*VW +: VW] = PORT_WIDE[p] ? dmem_wdata : VW'(dmem_wdata[DWIDTH-1:0]);
    end
  end

  assign dmem_resp  = (!rst && (cnt != '0)) ? cur_resp  : RESP_IDLE;
  assign dmem_rdata = (!rst && (cnt != '0)) ? cur_rdata : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      cur_port <= '0;
    end else begin
      if (accept) cur_port <= sel;
      if (accept && !retire)      cnt <= cnt + CW'(1);
      else if (retire && !accept) cnt <= cnt - CW'(1);
    end
  end

`ifdef SCR1_DMEM_ROUTER_ERR_CAPTURE_EN
  localparam int unsigned PW = (OUTST_DEPTH > 1) ? $clog2(OUTST_DEPTH) : 1;

  logic [AWIDTH-1:0] afifo [OUTST_DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
    return (ptr == PW'(OUTST_DEPTH-1)) ? '0 : ptr + PW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      err_valid <= 1'b0;
      err_port  <= '0;
      err_addr  <= '0;
    end else begin
      if (accept) begin
        afifo[wr_ptr] <= dmem_addr;
        wr_ptr        <= ptr_inc(wr_ptr);
      end
      if (retire) rd_ptr <= ptr_inc(rd_ptr);
      if (retire && (cur_resp == RESP_RDY_ER) && (!err_valid || err_clr)) begin
        err_valid <= 1'b1;
        err_port  <= cur_port;
        err_addr  <= afifo[rd_ptr];
      end else if (err_clr) begin
        err_valid <= 1'b0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_scr1_dmem_router_mp.sv
// Scoreboard bench for scr1_dmem_router_mp: directed requests, behavioural targets, in-order response check.
module tb_scr1_dmem_router_mp;

  localparam logic [1:0] R_IDLE = 2'b00;
  localparam logic [1:0] R_OK   = 2'b01;
  localparam logic [1:0] R_ER   = 2'b10;

  logic         clk = 1'b0;
  logic         rst;
  logic         dmem_req;
  logic         dmem_req_ack;
  logic         dmem_cmd;
  logic [1:0]   dmem_width;
  logic [31:0]  dmem_addr;
  logic [127:0] dmem_wdata;
  logic [127:0] dmem_rdata;
  logic [1:0]   dmem_resp;
  logic [2:0]   port_req;
  logic [2:0]   port_req_ack;
  logic [2:0]   port_cmd;
  logic [5:0]   port_width;
  logic [95:0]  port_addr;
  logic [383:0] port_wdata;
  logic [383:0] port_rdata;
  logic [5:0]   port_resp;
`ifdef SCR1_DMEM_ROUTER_ERR_CAPTURE_EN
  logic         err_clr;
  logic         err_valid;
  logic [1:0]   err_port;
  logic [31:0]  err_addr;
`endif

  always #5 clk = ~clk;

  scr1_dmem_router_mp #(
    .PORT_NUM    (3),
    .OUTST_DEPTH (2),
    .AWIDTH      (32),
    .DWIDTH      (32),
    .LANES       (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .dmem_req     (dmem_req),
    .dmem_req_ack (dmem_req_ack),
    .dmem_cmd     (dmem_cmd),
    .dmem_width   (dmem_width),
    .dmem_addr    (dmem_addr),
    .dmem_wdata   (dmem_wdata),
    .dmem_rdata   (dmem_rdata),
    .dmem_resp    (dmem_resp),
    .port_req     (port_req),
    .port_req_ack (port_req_ack),
    .port_cmd     (port_cmd),
    .port_width   (port_width),
    .port_addr    (port_addr),
    .port_wdata   (port_wdata),
    .port_rdata   (port_rdata),
    .port_resp    (port_resp)
`ifdef SCR1_DMEM_ROUTER_ERR_CAPTURE_EN
    ,
    .err_clr      (err_clr),
    .err_valid    (err_valid),
    .err_port     (err_port),
    .err_addr     (err_addr)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  typedef struct { int port; logic cmd; logic [31:0] addr; logic [127:0] wd; } req_exp_t;
  typedef struct { logic [1:0] resp; logic [127:0] rd; } rsp_exp_t;
  typedef struct { int port; int due; logic [1:0] resp; logic [127:0] data; } pend_t;

  req_exp_t req_q[$];
  rsp_exp_t rsp_q[$];
  pend_t    pq[$];

  // Target model: each port answers a fixed number of cycles after accepting.
  int          lat [3] = '{1, 3, 2};
  int          cyc = 0;
  logic [31:0] er_addr = 32'hFFFF_FFFF;

  function automatic logic [127:0] pdata(input int p, input logic [31:0] a);
    if (p == 2) return '1;
    return {a + 32'd3, a + 32'd2, a + 32'd1, a};
  endfunction

  initial begin
    port_resp  = '0;
    port_rdata = '0;
    forever begin
      @(negedge clk);
      for (int p = 0; p < 3; p++) begin
        if (port_req[p] && port_req_ack[p]) begin
          pend_t e;
          e.port = p;
          e.due  = cyc + lat[p];
          e.resp = (port_addr[p*32 +: 32] == er_addr) ? R_ER : R_OK;
          e.data = pdata(p, port_addr[p*32 +: 32]);
          pq.push_back(e);
        end
      end
      @(posedge clk);
      #1;
      cyc++;
      port_resp  = '0;
      port_rdata = '0;
      for (int i = pq.size() - 1; i >= 0; i--) begin
        if (pq[i].due == cyc) begin
          port_resp[2*pq[i].port +: 2]     = pq[i].resp;
          port_rdata[pq[i].port*128 +: 128] = pq[i].data;
          pq.delete(i);
        end
      end
    end
  end

  always @(negedge clk) begin : mon
    req_exp_t r;
    rsp_exp_t s;
    if (dmem_req_ack === 1'b1) begin
      if (req_q.size() == 0) begin
        chk("unexpected_accept", 128'(dmem_req_ack), 128'(0));
      end else begin
        r = req_q.pop_front();
        chk("req_onehot", 128'(port_req), 128'(3'b001 << r.port));
        chk("req_addr",   128'(port_addr[r.port*32 +: 32]), 128'(r.addr));
        chk("req_cmd",    128'(port_cmd[r.port]), 128'(r.cmd));
        chk("req_width",  128'(port_width[2*r.port +: 2]), 128'(2'b10));
        chk("req_wdata",  port_wdata[r.port*128 +: 128], r.wd);
      end
    end
    if (dmem_resp !== R_IDLE) begin
      if (rsp_q.size() == 0) begin
        chk("unexpected_resp", 128'(dmem_resp), 128'(R_IDLE));
      end else begin
        s = rsp_q.pop_front();
        chk("resp_code",  128'(dmem_resp), 128'(s.resp));
        chk("resp_rdata", dmem_rdata, s.rd);
      end
    end
  end

  task automatic drive_idle();
    dmem_req   = 1'b0;
    dmem_cmd   = 1'b0;
    dmem_width = 2'b10;
    dmem_addr  = '0;
    dmem_wdata = '0;
  endtask

  task automatic issue(input logic cmd, input logic [31:0] a, input logic [127:0] wd,
                       input int ep, input logic [127:0] ewd,
                       input logic [1:0] eresp, input logic [127:0] erd, output int stalls);
    req_exp_t r;
    rsp_exp_t s;
    logic     acc;
    r.port = ep; r.cmd = cmd; r.addr = a; r.wd = ewd;
    s.resp = eresp; s.rd = erd;
    req_q.push_back(r);
    rsp_q.push_back(s);
    dmem_req   = 1'b1;
    dmem_cmd   = cmd;
    dmem_width = 2'b10;
    dmem_addr  = a;
    dmem_wdata = wd;
    stalls     = 0;
    acc        = 1'b0;
    for (int k = 0; k <= 30; k++) begin
      @(negedge clk);
      if (dmem_req_ack === 1'b1) begin
        acc = 1'b1;
        break;
      end
      stalls++;
      @(posedge clk);
      #1;
    end
    if (!acc) chk("accept_timeout", 128'(dmem_req_ack), 128'(1));
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 60; k++) begin
      if (rsp_q.size() == 0) break;
      @(posedge clk);
      #1;
    end
    if (rsp_q.size() != 0) chk("drain_timeout", 128'(rsp_q.size()), 128'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    logic [127:0] w;
    int st0, st1, st2;
    w = 128'h44444444_33333333_22222222_11111111;
    rst = 1'b1;
    drive_idle();
    port_req_ack = 3'b111;
`ifdef SCR1_DMEM_ROUTER_ERR_CAPTURE_EN
    err_clr = 1'b0;
`endif

    // Reset: request held high must be gated off
    @(posedge clk); #1;
    dmem_req  = 1'b1;
    dmem_addr = 32'h00010004;
    @(negedge clk);
    chk("rst_port_req", 128'(port_req), 128'(0));
    chk("rst_req_ack",  128'(dmem_req_ack), 128'(0));
    chk("rst_resp",     128'(dmem_resp), 128'(R_IDLE));
    chk("rst_rdata",    dmem_rdata, 128'(0));
`ifdef SCR1_DMEM_ROUTER_ERR_CAPTURE_EN
    chk("rst_err_valid", 128'(err_valid), 128'(0));
`endif
    @(posedge clk); #1;
    rst = 1'b0;
    drive_idle();

    // Decode and default route
    issue(1'b0, 32'h00010004, w, 1, w, R_OK, 128'h00010007_00010006_00010005_00010004, st0);
    drive_idle(); wait_drain();
    issue(1'b0, 32'h00020000, w, 2, 128'h11111111, R_OK, {96'h0, 32'hFFFFFFFF}, st0);
    drive_idle(); wait_drain();
    issue(1'b0, 32'h00030000, w, 0, 128'h11111111, R_OK, 128'h00030000, st0);
    drive_idle(); wait_drain();

    // Narrow write formatting
    issue(1'b1, 32'h00020000, w, 2, 128'h11111111, R_OK, {96'h0, 32'hFFFFFFFF}, st0);
    drive_idle(); wait_drain();

    // Pipelining on port 1: third request waits for the first retire
    issue(1'b0, 32'h00010010, w, 1, w, R_OK, 128'h00010013_00010012_00010011_00010010, st0);
    issue(1'b0, 32'h00010020, w, 1, w, R_OK, 128'h00010023_00010022_00010021_00010020, st1);
    issue(1'b0, 32'h00010030, w, 1, w, R_OK, 128'h00010033_00010032_00010031_00010030, st2);
    drive_idle();
    chk("pipe_stall_1st", 128'(st0), 128'(0));
    chk("pipe_stall_2nd", 128'(st1), 128'(0));
    chk("pipe_stall_3rd", 128'(st2), 128'(1));
    wait_drain();

    // Port switch waits for port 1 to answer, accepted in that cycle
    issue(1'b0, 32'h00010040, w, 1, w, R_OK, 128'h00010043_00010042_00010041_00010040, st0);
    issue(1'b0, 32'h00020004, w, 2, 128'h11111111, R_OK, {96'h0, 32'hFFFFFFFF}, st1);
    drive_idle();
    chk("switch_stall", 128'(st1), 128'(2));
    wait_drain();

    // Target withholds ack: request still presented, core not acked
    port_req_ack = 3'b110;
    fork
      issue(1'b0, 32'h00030010, w, 0, 128'h11111111, R_OK, 128'h00030010, st0);
      begin
        @(negedge clk);
        chk("noack_port_req", 128'(port_req), 128'(3'b001));
        chk("noack_req_ack",  128'(dmem_req_ack), 128'(0));
        @(posedge clk); #1;
        port_req_ack = 3'b111;
      end
    join
    drive_idle();
    chk("noack_stall", 128'(st0), 128'(1));
    wait_drain();

    // Reset with two outstanding: late responses must be ignored
    issue(1'b0, 32'h00010050, w, 1, w, R_OK, 128'h0, st0);
    issue(1'b0, 32'h00010060, w, 1, w, R_OK, 128'h0, st1);
    rst       = 1'b1;
    dmem_req  = 1'b1;
    dmem_addr = 32'h00010070;
    rsp_q.delete();
    @(negedge clk);
    chk("midrst_port_req", 128'(port_req), 128'(0));
    chk("midrst_req_ack",  128'(dmem_req_ack), 128'(0));
    chk("midrst_resp",     128'(dmem_resp), 128'(R_IDLE));
    @(posedge clk); #1;
    rst = 1'b0;
    drive_idle();
    @(negedge clk);
    chk("late_resp1_idle",  128'(dmem_resp), 128'(R_IDLE));
    chk("late_resp1_rdata", dmem_rdata, 128'(0));
    @(posedge clk); #1;
    @(negedge clk);
    chk("late_resp2_idle",  128'(dmem_resp), 128'(R_IDLE));
    @(posedge clk); #1;
    issue(1'b0, 32'h00020008, w, 2, 128'h11111111, R_OK, {96'h0, 32'hFFFFFFFF}, st0);
    drive_idle(); wait_drain();

`ifdef SCR1_DMEM_ROUTER_ERR_CAPTURE_EN
    // Error capture: second outstanding entry answered with an error
    er_addr = 32'h00010008;
    issue(1'b0, 32'h00010004, w, 1, w, R_OK, 128'h00010007_00010006_00010005_00010004, st0);
    issue(1'b0, 32'h00010008, w, 1, w, R_ER, 128'h0001000B_0001000A_00010009_00010008, st1);
    drive_idle(); wait_drain();
    chk("err_valid_set", 128'(err_valid), 128'(1));
    chk("err_port",      128'(err_port),  128'(1));
    chk("err_addr",      128'(err_addr),  128'(32'h00010008));
    er_addr = 32'h0001000C;
    issue(1'b0, 32'h0001000C, w, 1, w, R_ER, 128'h0001000F_0001000E_0001000D_0001000C, st0);
    drive_idle(); wait_drain();
    chk("err_sticky_valid", 128'(err_valid), 128'(1));
    chk("err_sticky_addr",  128'(err_addr),  128'(32'h00010008));
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    chk("err_cleared", 128'(err_valid), 128'(0));
`endif

    repeat (3) @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/scr1_dmem_router_mp.md
Name: scr1_dmem_router_mp

Overview:
- Parametrised N-port data-memory router between the core LSU data interface and PORT_NUM memory/peripheral targets.
- Decodes each request address against per-port mask/pattern pairs.
- Allows up to OUTST_DEPTH pipelined outstanding requests, and returns responses to the core in issue order.
- Supports mixed-width targets: "wide" ports carry the full LANES-lane vector; "narrow" ports carry lane 0 only.

Parameters:
- PORT_NUM, 3: number of target ports. Range 2..8. Port 0 is the default (no-match) target.
- OUTST_DEPTH, 2: maximum outstanding accepted-but-unanswered requests. Range 1..8.
- AWIDTH, 32: address width.
- DWIDTH, 32: lane data width.
- LANES, 4: lanes per vector beat.
- ADDR_MASK, {PORT_NUM{32'hFFFF0000}}: packed per-port mask, PORT_NUM*AWIDTH bits. The entry for port 0 is unused.
- ADDR_PATTERN, {32'h00020000, 32'h00010000, 32'h0}: packed per-port pattern, PORT_NUM*AWIDTH bits. Port i sits at [i*AWIDTH +: AWIDTH].
- PORT_WIDE, 3'b010: bit i set means port i is wide (LANES*DWIDTH data); bit clear means narrow (lane 0 only).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- dmem_req  in  1  core request
- dmem_req_ack  out  1  request accepted this cycle
- dmem_cmd  in  1  type_scr1_mem_cmd_e
- dmem_width  in  2  type_scr1_mem_width_e
- dmem_addr  in  AWIDTH  request address
- dmem_wdata  in  LANES*DWIDTH  write vector, lane 0 in the LSBs
- dmem_rdata  out  LANES*DWIDTH  read vector
- dmem_resp  out  2  type_scr1_mem_resp_e
- port_req  out  PORT_NUM  per-port request
- port_req_ack  in  PORT_NUM  per-port accept
- port_cmd  out  PORT_NUM  per-port cmd
- port_width  out  2*PORT_NUM  per-port width
- port_addr  out  PORT_NUM*AWIDTH  per-port address
- port_wdata  out  PORT_NUM*LANES*DWIDTH  per-port write data
- port_rdata  in  PORT_NUM*LANES*DWIDTH  per-port read data
- port_resp  in  2*PORT_NUM  per-port response

Behaviour:
- Decode (combinational):
  - sel is the lowest i in 1..PORT_NUM-1 with (dmem_addr & MASK[i]) == PATTERN[i].
  - If no port matches, sel = 0.
- State:
  - cnt: 0..OUTST_DEPTH.
  - cur_port: index of the port that owns all outstanding requests.
  - All outstanding requests always target a single port; this is what guarantees in-order responses.
- retire = (cnt != 0) & (port_resp[cur_port] ∈ {RDY_OK, RDY_ER}).
- can_issue = (cnt == 0) | (sel == cur_port & (cnt < OUTST_DEPTH | retire)) | (cnt == 1 & retire).
  - The (cnt == 1 & retire) term means a port switch is allowed only once the pipe is drained or draining this cycle.
- Request outputs:
  - port_req[p] = ~rst & dmem_req & can_issue & (sel == p). It never depends on port_req_ack.
  - dmem_req_ack = port_req_ack[sel] & port_req[sel].
- Fan-out to ports:
  - cmd, width and addr are routed to port sel. Non-selected ports see cmd/width ERROR and addr 'x.
  - Wide port: port_wdata gets the full vector.
  - Narrow port: port_wdata gets lane 0 in the low DWIDTH bits, upper lanes zero.
- Accept (dmem_req_ack = 1): cur_port <= sel.
- Counter update, evaluated on the same edge:
  - cnt <= cnt + 1 on accept without retire.
  - cnt <= cnt - 1 on retire without accept.
  - cnt unchanged when both occur.
- Response path:
  - When cnt != 0: dmem_resp = port_resp[cur_port] and dmem_rdata = port_rdata[cur_port].
  - Narrow port: upper lanes of dmem_rdata forced to 0.
  - When cnt == 0: dmem_resp = IDLE and dmem_rdata = 0.
  - Responses from ports other than cur_port, or any response while cnt == 0, are ignored.
- RDY_ER is forwarded unchanged and retires exactly one entry. Remaining outstanding entries still complete normally.
- Reset:
  - cnt = 0 and cur_port = 0.
  - While rst is high: port_req = 0, dmem_req_ack = 0, dmem_resp = IDLE, dmem_rdata = 0.
  - Reset asserted mid-transaction discards all outstanding state. Late responses arriving after reset are ignored because cnt == 0.
- Latency:
  - Zero added cycles on both the request and response paths.
  - Throughput is one request per cycle while the target stays on the same port.

Optional Feature:
- Macro: SCR1_DMEM_ROUTER_ERR_CAPTURE_EN.
- When defined:
  - Adds an address FIFO of depth OUTST_DEPTH, pushed on accept and popped on retire.
  - Adds sticky outputs err_valid (1), err_port ($clog2(PORT_NUM)) and err_addr (AWIDTH), plus input err_clr (1).
  - The first retire with RDY_ER while err_valid == 0 captures cur_port and the FIFO head address, and sets err_valid on the next edge.
  - Later errors do not overwrite the capture.
  - err_clr clears err_valid. If err_clr and a new error occur in the same cycle, the new error is captured.
  - Reset clears all three outputs to 0.
- When undefined: no FIFO and no extra ports. Behaviour is otherwise identical.

Test Plan:
- Decode and default route, all acks 1: addr 0x00010004 -> port_req[1]; 0x00020000 -> port_req[2]; 0x00030000 -> port_req[0].
- Narrow-port data formatting: write 128-bit vector to 0x00020000 -> port_wdata[2] = {96'h0, lane0}. Read with port2 rdata = 128'hFFFF...FFFF -> dmem_rdata = {96'h0, 32'hFFFFFFFF}.
- Pipelining, OUTST_DEPTH = 2, port 1 responding 3 cycles after each accept, back-to-back reads to port 1:
  - Two accepts in consecutive cycles, third request stalls with dmem_req_ack = 0.
  - Third request is accepted in the first retire cycle; cnt goes 1, 2, 2.
- Port switch: request to port 2 issued while cnt = 1 on port 1 -> dmem_req_ack held 0 until port 1 responds RDY_OK, then accepted in that same cycle.
- Reset mid-operation: assert rst with cnt = 2 -> cnt = 0, outputs idle. A port response after reset gives dmem_resp = IDLE.
- Error capture (macro defined): second outstanding request (to 0x00010008) answered RDY_ER -> err_valid = 1, err_port = 1, err_addr = 0x00010008. A later error leaves them unchanged; err_clr clears err_valid.
